// File: rtl/sobel_window_gen_pkg.sv
// Shared constants and the window slot helper for the Sobel window generator
// and the convolution stage that consumes its packed 3x3 window.
package sobel_window_gen_pkg;

  localparam int SOBEL_DATA_W = 8;
  localparam int SOBEL_WIN_W  = 9 * SOBEL_DATA_W;

  // Bit offset of window slot (row, col); row 0 is the oldest line, col 2 the newest pixel.
  function automatic int win_slot(input int row, input int col, input int data_w);
    return (row * 3 + col) * data_w;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage with a combinational read that returns the value
// held before the write on the same clock edge (read-before-write).
module sobel_line_buffer #(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = 8,
  localparam int AW       = $clog2(IMG_WIDTH)
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [IMG_WIDTH];

  assign rd_data = mem[addr];

  // NOTE: the storage array has no reset; its contents are never emitted before
  // being rewritten, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator: two line buffers, a 3-column shift window
// and a registered valid / frame-done pair with one clock of latency.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = SOBEL_DATA_W
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                pixel_sof_in,
  input  logic [DATA_W-1:0]   pixel_data_in,
  input  logic                pixel_data_valid_in,
  output logic [9*DATA_W-1:0] pixel_data_out,
  output logic                pixel_data_valid_out,
  output logic                frame_done_out
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic [XW-1:0]       col_cnt, cur_x, nxt_x;
  logic [YW-1:0]       row_cnt, cur_y, nxt_y;
  logic                at_eol, at_eof, win_ok;
  logic [DATA_W-1:0]   lb1_rd, lb2_rd;
  logic [DATA_W-1:0]   col_in [3];
  logic [9*DATA_W-1:0] win_q, win_d;
  logic                valid_q, done_q;

  // Line y-1 feeds line y-2: LB2 takes the value LB1 held before this write.
  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
    .Clk     (Clk),
    .wr_en   (pixel_data_valid_in),
    .addr    (cur_x),
    .wr_data (pixel_data_in),
    .rd_data (lb1_rd)
  );

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb2 (
    .Clk     (Clk),
    .wr_en   (pixel_data_valid_in),
    .addr    (cur_x),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // NOTE: every signal written in an always_comb is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_x  = col_cnt;
    cur_y  = row_cnt;
    nxt_x  = '0;
    nxt_y  = '0;
    if (pixel_sof_in) begin
      cur_x = '0;
      cur_y = '0;
    end
    at_eol = (cur_x == XW'(IMG_WIDTH - 1));
    at_eof = at_eol && (cur_y == YW'(IMG_HEIGHT - 1));
    win_ok = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    if (at_eol) begin
      nxt_x = '0;
      nxt_y = at_eof ? '0 : cur_y + YW'(1);
    end else begin
      nxt_x = cur_x + XW'(1);
      nxt_y = cur_y;
    end
  end

  always_comb begin
    col_in[0] = lb2_rd;
    col_in[1] = lb1_rd;
    col_in[2] = pixel_data_in;
    win_d     = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[win_slot(r, 0, DATA_W) +: DATA_W] = win_q[win_slot(r, 1, DATA_W) +: DATA_W];
      win_d[win_slot(r, 1, DATA_W) +: DATA_W] = win_q[win_slot(r, 2, DATA_W) +: DATA_W];
      win_d[win_slot(r, 2, DATA_W) +: DATA_W] = col_in[r];
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= pixel_data_valid_in && win_ok;
      done_q  <= pixel_data_valid_in && win_ok && at_eof;
      if (pixel_data_valid_in) begin
        col_cnt <= nxt_x;
        row_cnt <= nxt_y;
        win_q   <= win_d;
      end
    end
  end

  assign pixel_data_out       = win_q;
  assign pixel_data_valid_out = valid_q;
  assign frame_done_out       = done_q;

endmodule
